pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: WAIT_TIMEOUT, default 15, max consecutive memory-wait cycles before fault.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous reset, active-low.
REQ-004 Rs1D, Rs2D  in  5 each  decode-stage source registers.
REQ-005 Rs1E, Rs2E, RdE  in  5 each  execute-stage source/destination registers.
REQ-006 RdM, RdW  in  5 each  memory/writeback destination registers.
REQ-007 resultSrcE  in  2  execute result select; 2'b01 = load.
REQ-008 regWriteM, regWriteW  in  1 each  register-write enables of M and W.
REQ-009 PCSrcE  in  1  taken branch/jump resolved in E.
REQ-010 memReqM, memReadyM  in  1 each  data-memory request in M; memory ready.
REQ-011 stallF, stallD, stallE, stallM  out  1 each  hold the respective pipeline register (drives enable = ~stall).
REQ-012 flushD, flushE, flushW  out  1 each  clear the respective pipeline register next edge.
REQ-013 forwardAE, forwardBE  out  2 each  ALU operand select: 00 regfile, 01 W result, 10 M ALU result.
REQ-014 memFault  out  1  sticky memory-timeout flag.
REQ-015 state  out  2  FSM state, debug.

Function
REQ-016 FSM states: RUN=00, MEM_WAIT=01, FAULT=10; 11 unreachable, decodes as RUN.
REQ-017 RUN -> MEM_WAIT when memReqM=1 and memReadyM=0; same cycle asserts stallF/D/E/M and flushW (combinational from inputs).
REQ-018 MEM_WAIT: stallF/D/E/M=1, flushW=1, flushD=flushE=0; PCSrcE and load-use ignored.
REQ-019 MEM_WAIT -> RUN on memReadyM=1; stalls deassert that same cycle.
REQ-020 MEM_WAIT wait counter (4-bit min, sized from WAIT_TIMEOUT) clears on entry, increments each MEM_WAIT cycle; reaching WAIT_TIMEOUT with memReadyM=0 -> FAULT.
REQ-021 FAULT: all stalls=1, flushW=1, memFault=1; exit only by reset.
REQ-022 Load-use hazard (RUN only): resultSrcE=01, RdE!=0, RdE equals Rs1D or Rs2D -> stallF=stallD=1, flushE=1, one cycle.
REQ-023 Branch (RUN only): PCSrcE=1 -> flushD=flushE=1, no stalls; branch overrides simultaneous load-use.
REQ-024 Memory stall overrides branch and load-use in the same cycle; branch re-evaluated when E releases.
REQ-025 Forwarding: 10 if regWriteM, RdM!=0, RdM==Rs1E; else 01 if regWriteW, RdW!=0, RdW==Rs1E; else 00; same rule for Rs2E/forwardBE; M beats W; valid in all states.
REQ-026 Register x0 never triggers forwarding or load-use stall.

Reset
REQ-027 On rst=0: state=RUN, wait counter=0, memFault=0, perf counters=0; stalls/flushes follow RUN combinational rules.
REQ-028 Reset mid-MEM_WAIT or in FAULT returns to RUN immediately, asynchronously.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN defined: add outputs stallCycles (16) and flushCount (16), saturating at 16'hFFFF; stallCycles counts cycles with stallF=1; flushCount counts cycles with flushD or flushE=1.
REQ-030 Macro undefined: no counter ports, no counter logic; all other behaviour identical.

Structure
REQ-031 Shared package hazard_pkg: FSM state encoding, forward-select constants (FWD_RF, FWD_W, FWD_M), RESULT_SRC_LOAD=2'b01.
REQ-032 One sub-module, wait_timer: clear/increment/expired counter parameterised by WAIT_TIMEOUT.

Verification
REQ-033 RdM=5, regWriteM=1, Rs1E=5, RdW=5, regWriteW=1 -> forwardAE=10; regWriteM=0 -> 01; RdM=RdW=0 -> 00.
REQ-034 resultSrcE=01, RdE=7, Rs2D=7, PCSrcE=0 -> one cycle stallF=stallD=flushE=1; next cycle (bubble, resultSrcE=00) all 0.
REQ-035 Same load-use plus PCSrcE=1 -> flushD=flushE=1, stallF=stallD=0.
REQ-036 memReqM=1, memReadyM=0 for 3 cycles then 1 -> state 01 for 3 cycles, all stalls and flushW=1, back to RUN, stalls 0 on ready cycle.
REQ-037 memReadyM held 0 with WAIT_TIMEOUT=15 -> FAULT after 15 wait cycles, memFault=1 until rst=0, then state=00, memFault=0.
REQ-038 HAZARD_PERF_CNT_EN defined, 4 stall cycles plus 2 branches -> stallCycles=4, flushCount=2; forced near-saturation holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// forward-select codes, result-select load code and control helpers.
package hazard_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT16_W = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FAULT    = 2'b10,
    ST_RSVD     = 2'b11
  } state_e;

  localparam logic [SEL_W-1:0] FWD_RF = 2'b00;
  localparam logic [SEL_W-1:0] FWD_W  = 2'b01;
  localparam logic [SEL_W-1:0] FWD_M  = 2'b10;

  localparam logic [SEL_W-1:0] RESULT_SRC_LOAD = 2'b01;

  // Pipeline-register control bundle (stall = hold, flush = clear).
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_HOLD = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                     stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0,
                                     flush_w: 1'b1};

  // Normal-running priority: memory stall > branch flush > load-use bubble.
  function automatic hz_ctrl_t run_ctrl(input logic mem_block,
                                        input logic branch,
                                        input logic load_use);
    hz_ctrl_t c;
    c = '0;
    if (mem_block) begin
      c = CTRL_HOLD;
    end else if (branch) begin
      c.flush_d = 1'b1;
      c.flush_e = 1'b1;
    end else if (load_use) begin
      c.stall_f = 1'b1;
      c.stall_d = 1'b1;
      c.flush_e = 1'b1;
    end
    return c;
  endfunction

  // Operand bypass select; the M stage is younger so it wins over W, x0 never forwards.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                               input logic [REG_W-1:0] rd_m,
                                               input logic             wr_m,
                                               input logic [REG_W-1:0] rd_w,
                                               input logic             wr_w);
    logic [SEL_W-1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_wait_timer.sv
// Memory-wait cycle counter: cleared outside the wait, counts wait cycles,
// flags the cycle on which the configured wait budget is used up.
module wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired_c
);

  localparam int unsigned CLOG_W = $clog2(WAIT_TIMEOUT + 1);
  localparam int unsigned CNT_W  = (CLOG_W > 4) ? CLOG_W : 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Wait counter; holds once expired so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !expired_c) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = (count == LAST);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use bubbles,
// branch flushes and a memory-wait FSM with timeout fault.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic [SEL_W-1:0] resultSrcE,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             PCSrcE,
  input  logic             memReqM,
  input  logic             memReadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [SEL_W-1:0] forwardAE,
  output logic [SEL_W-1:0] forwardBE,
  output logic             memFault,
  output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT16_W-1:0] stallCycles,
  output logic [CNT16_W-1:0] flushCount
`endif
);

  state_e   state_q;
  state_e   state_d;
  hz_ctrl_t ctrl;
  logic     load_use_c;
  logic     mem_block_c;
  logic     expired_c;

  assign load_use_c  = (resultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_block_c = memReqM && !memReadyM;

  wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst),
    .clear    (state_q != ST_MEM_WAIT),
    .inc      ((state_q == ST_MEM_WAIT) && !memReadyM),
    .expired_c(expired_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and pipeline control; the unused encoding behaves as RUN.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      ST_MEM_WAIT: begin
        if (memReadyM) begin
          state_d = ST_RUN;
          ctrl    = run_ctrl(1'b0, PCSrcE, load_use_c);
        end else begin
          ctrl = CTRL_HOLD;
          if (expired_c) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        ctrl = CTRL_HOLD;
      end
      default: begin
        ctrl = run_ctrl(mem_block_c, PCSrcE, load_use_c);
        if (mem_block_c) begin
          state_d = ST_MEM_WAIT;
        end
      end
    endcase
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memFault <= 1'b0;
    end else if (state_d == ST_FAULT) begin
      memFault <= 1'b1;
    end
  end

  assign stallF    = ctrl.stall_f;
  assign stallD    = ctrl.stall_d;
  assign stallE    = ctrl.stall_e;
  assign stallM    = ctrl.stall_m;
  assign flushD    = ctrl.flush_d;
  assign flushE    = ctrl.flush_e;
  assign flushW    = ctrl.flush_w;
  assign state     = state_q;
  assign forwardAE = fwd_sel(Rs1E, RdM, regWriteM, RdW, regWriteW);
  assign forwardBE = fwd_sel(Rs2E, RdM, regWriteM, RdW, regWriteW);

`ifdef HAZARD_PERF_CNT_EN
  // Saturating performance counters for fetch stalls and D/E flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (ctrl.stall_f && (stallCycles != '1)) begin
        stallCycles <= stallCycles + CNT16_W'(1);
      end
      if ((ctrl.flush_d || ctrl.flush_e) && (flushCount != '1)) begin
        flushCount <= flushCount + CNT16_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] resultSrcE;
  logic       regWriteM, regWriteW, PCSrcE, memReqM, memReadyM;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0] forwardAE, forwardBE;
  logic       memFault;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stallCycles, flushCount;
`endif
  logic [6:0] ctl;

  int vectors = 0;
  int miscompares = 0;

  assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

  pipeline_hazard_ctrl #(.WAIT_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .resultSrcE(resultSrcE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .PCSrcE(PCSrcE), .memReqM(memReqM), .memReadyM(memReadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .memFault(memFault), .state(state)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCycles(stallCycles), .flushCount(flushCount)
`endif
  );

  always #5 clk = ~clk;

  // ctl bit order: stallF stallD stallE stallM flushD flushE flushW
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_HOLD = 7'b1111001;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    resultSrcE = 2'b00; regWriteM = 1'b0; regWriteW = 1'b0;
    PCSrcE = 1'b0; memReqM = 1'b0; memReadyM = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_fault", 32'(memFault), 32'd0);
    chk("reset_ctl", 32'(ctl), 32'(C_NONE));
    memReqM = 1'b1; memReadyM = 1'b0;
    #1;
    chk("reset_run_rules", 32'(ctl), 32'(C_HOLD));
    chk("reset_state_held", 32'(state), 32'd0);
    clear_inputs();
    rst = 1'b1;
    tick();

    // Forwarding
    RdM = 5'd5; regWriteM = 1'b1; Rs1E = 5'd5; RdW = 5'd5; regWriteW = 1'b1;
    #1; chk("fwdA_m_wins", 32'(forwardAE), 32'd2);
    regWriteM = 1'b0;
    #1; chk("fwdA_w", 32'(forwardAE), 32'd1);
    regWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0;
    #1; chk("fwdA_x0", 32'(forwardAE), 32'd0);
    Rs2E = 5'd9; RdW = 5'd9; RdM = 5'd3;
    #1; chk("fwdB_w", 32'(forwardBE), 32'd1);
    Rs1E = 5'd0; RdM = 5'd0;
    #1; chk("fwdA_rs_x0", 32'(forwardAE), 32'd0);
    clear_inputs();

    // Load-use
    resultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd3;
    #1; chk("loaduse", 32'(ctl), 32'(C_LU));
    tick();
    resultSrcE = 2'b00;
    #1; chk("loaduse_bubble", 32'(ctl), 32'(C_NONE));
    resultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    #1; chk("loaduse_x0", 32'(ctl), 32'(C_NONE));
    RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    #1; chk("branch_over_loaduse", 32'(ctl), 32'(C_BR));
    tick();
    clear_inputs();

    // Memory wait of three cycles
    memReqM = 1'b1; memReadyM = 1'b0; PCSrcE = 1'b1;
    resultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1; chk("mw_entry_ctl", 32'(ctl), 32'(C_HOLD));
    chk("mw_entry_state", 32'(state), 32'd0);
    tick();
    chk("mw1_state", 32'(state), 32'd1);
    chk("mw1_ctl", 32'(ctl), 32'(C_HOLD));
    tick();
    chk("mw2_state", 32'(state), 32'd1);
    chk("mw2_ctl", 32'(ctl), 32'(C_HOLD));
    tick();
    chk("mw3_state", 32'(state), 32'd1);
    chk("mw3_ctl_wait", 32'(ctl), 32'(C_HOLD));
    memReadyM = 1'b1;
    #1; chk("mw3_ready_branch", 32'(ctl), 32'(C_BR));
    PCSrcE = 1'b0; resultSrcE = 2'b00;
    #1; chk("mw3_ready_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("mw_exit_state", 32'(state), 32'd0);
    clear_inputs();

    // Timeout to FAULT
    memReqM = 1'b1; memReadyM = 1'b0;
    #1; chk("to_entry_state", 32'(state), 32'd0);
    tick();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to_wait%0d_state", i), 32'(state), 32'd1);
      chk($sformatf("to_wait%0d_fault", i), 32'(memFault), 32'd0);
      tick();
    end
    chk("fault_state", 32'(state), 32'd2);
    chk("fault_flag", 32'(memFault), 32'd1);
    chk("fault_ctl", 32'(ctl), 32'(C_HOLD));
    memReadyM = 1'b1; memReqM = 1'b0;
    tick(); tick();
    chk("fault_sticky_state", 32'(state), 32'd2);
    chk("fault_sticky_flag", 32'(memFault), 32'd1);
    chk("fault_sticky_ctl", 32'(ctl), 32'(C_HOLD));
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_fault", 32'(memFault), 32'd0);
    chk("async_rst_ctl", 32'(ctl), 32'(C_NONE));
    rst = 1'b1;
    tick();
    clear_inputs();

`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b0; #1; rst = 1'b1;
    chk("perf_reset_stall", 32'(stallCycles), 32'd0);
    chk("perf_reset_flush", 32'(flushCount), 32'd0);
    memReqM = 1'b1; memReadyM = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    memReadyM = 1'b1;
    tick();
    memReqM = 1'b0; PCSrcE = 1'b1;
    tick(); tick();
    PCSrcE = 1'b0;
    tick();
    chk("perf_stall4", 32'(stallCycles), 32'd4);
    chk("perf_flush2", 32'(flushCount), 32'd2);
    resultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    for (int i = 0; i < 65540; i++) tick();
    chk("perf_stall_sat", 32'(stallCycles), 32'hFFFF);
    chk("perf_flush_sat", 32'(flushCount), 32'hFFFF);
    clear_inputs();
    tick();
    chk("perf_stall_hold", 32'(stallCycles), 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
